// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous fifo, its stream reader and benches.
//   WIDTH_DEF : default data word width
//   beat_t    : one stream beat (data plus valid)
package fifo_pkg;

  localparam int WIDTH_DEF = 32;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] data;
    logic                 valid;
  } beat_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ready output buffer. Words enter through push and leave
// from the head slot on a valid/ready handshake.
//   clk, arstn     : clock, async active-low reset
//   push/push_data : write one word into the buffer this edge
//   ready          : downstream ready
//   data/valid     : registered head word and its valid flag
//   pop            : handshake this cycle (valid & ready)
//   occ            : number of buffered words, 0..2
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             pop,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;

  assign valid = (occ != 2'd0);
  assign data  = head;
  assign pop   = valid & ready;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      head <= '0;
      tail <= '0;
      occ  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head <= push_data;
          else             tail <= push_data;
          occ <= occ + 2'd1;
        end
        2'b11: begin
          // Head leaves while a new word arrives: keep arrival order.
          if (occ == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side engine for the synchronous fifo. Drains the fifo and presents
// words on a valid/ready stream at one word per cycle, absorbing the fifo's
// one-cycle read latency with a two-entry buffer.
//   clk, arstn       : clock, async active-low reset
//   enable           : allow new fifo reads
//   fifo_read        : read strobe to the fifo (combinational)
//   fifo_data        : fifo output, valid the cycle after a read
//   fifo_empty       : fifo empty flag
//   m_data, m_valid  : stream output (registered)
//   m_ready          : stream ready from consumer
//   beat_cnt         : accepted beats, wrapping
//   busy             : read in flight or word buffered
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             enable,
  output logic             fifo_read,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_empty,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             busy
);

  logic       rd_pend;
  logic       pop;
  logic [1:0] occ;
  logic [2:0] level;
  logic       room;

  stream_skid_buf #(.WIDTH(WIDTH)) u_buf (
    .clk       (clk),
    .arstn     (arstn),
    .push      (rd_pend),
    .push_data (fifo_data),
    .ready     (m_ready),
    .data      (m_data),
    .valid     (m_valid),
    .pop       (pop),
    .occ       (occ)
  );

  // Words committed to the buffer: stored plus the one in flight.
  assign level = {1'b0, occ} + {2'b00, rd_pend};
  // level - pop < 2, kept unsigned.
  assign room  = (level < 3'd2) | (pop & (level == 3'd2));

  // Gated by arstn so no strobe leaks to the fifo while held in reset.
  assign fifo_read = arstn & enable & ~fifo_empty & room;
  assign busy      = rd_pend | (occ != 2'd0);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      rd_pend  <= 1'b0;
      beat_cnt <= '0;
    end else begin
      rd_pend <= fifo_read;
      if (pop) beat_cnt <= beat_cnt + 1'b1;
    end
  end

  always @(posedge clk) begin
    if (arstn) assert (level <= 3'd2);
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;
  import fifo_pkg::*;

  logic        clk = 1'b0;
  logic        arstn;
  logic        enable;
  logic        fifo_read;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] beat_cnt;
  logic        busy;

  fifo_stream_reader #(.WIDTH(32), .CNT_W(16)) dut (
    .clk        (clk),
    .arstn      (arstn),
    .enable     (enable),
    .fifo_read  (fifo_read),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .beat_cnt   (beat_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Fifo contents, words handed out but not yet accepted, and observations.
  int          fq[$];
  logic [31:0] exp_q[$];
  int          got[$];
  int          pop_cyc[$];
  int n_rd, n_pop, cyc, first_rd, first_v, rd_pulses;
  logic rd_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    got.delete(); pop_cyc.delete();
    cyc = 0; first_rd = -1; first_v = -1; rd_pulses = 0;
  endtask

  task automatic preload(input int first, input int n);
    for (int i = 0; i < n; i++) fq.push_back(first + i);
    fifo_empty = (fq.size() == 0);
  endtask

  // One cycle: drive inputs, compare every output against the model, then
  // advance the model and the bench fifo across the rising edge.
  task automatic step(input logic en, input logic rdy, input logic wr, input int wv);
    int outstanding, buffered;
    logic exp_rd, rd, pop;
    beat_t obs;
    @(negedge clk);
    enable = en; m_ready = rdy;
    #1;
    obs = '{data: m_data, valid: m_valid};
    outstanding = n_rd - n_pop;
    buffered = outstanding - (rd_last ? 1 : 0);
    chk("m_valid", obs.valid, buffered > 0);
    if (obs.valid && buffered > 0) chk("m_data", obs.data, exp_q[0]);
    pop = obs.valid & m_ready;
    exp_rd = arstn && en && !fifo_empty && ((outstanding - int'(pop)) < 2);
    chk("fifo_read", fifo_read, exp_rd);
    chk("busy", busy, outstanding > 0);
    chk("beat_cnt", beat_cnt, 16'(n_pop));
    rd = fifo_read;
    if (rd) begin
      rd_pulses++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (obs.valid && first_v < 0) first_v = cyc;
    if (pop) begin got.push_back(int'(obs.data)); pop_cyc.push_back(cyc); end
    @(posedge clk);
    #1;
    if (arstn) begin
      if (pop) begin
        n_pop++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (rd) begin
        n_rd++;
        if (fq.size() > 0) begin
          fifo_data = fq.pop_front();
          exp_q.push_back(fifo_data);
        end
      end
      rd_last = rd;
    end
    if (wr) fq.push_back(wv);
    fifo_empty = (fq.size() == 0);
    cyc++;
  endtask

  task automatic check_seq(input string name, input int first, input int n);
    int errs;
    errs = (got.size() == n) ? 0 : 1;
    for (int i = 0; i < got.size() && i < n; i++)
      if (got[i] != first + i) errs++;
    chk(name, errs, 0);
  endtask

  initial begin
    n_rd = 0; n_pop = 0; rd_last = 1'b0;
    clear_obs();
    arstn = 1'b0; enable = 1'b1; m_ready = 1'b0;
    fifo_data = '0; fifo_empty = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_beat_cnt", beat_cnt, 16'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fifo_read", fifo_read, 1'b0);
    fifo_empty = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    arstn = 1'b1;

    // Full-throughput drain of 1..16.
    clear_obs(); preload(1, 16);
    for (int i = 0; i < 22; i++) step(1'b1, 1'b1, 1'b0, 0);
    chk("t1_first_read_cycle", first_rd, 0);
    chk("t1_first_valid_cycle", first_v, 2);
    check_seq("t1_order", 1, 16);
    chk("t1_beat_cnt", beat_cnt, 16'd16);
    chk("t1_busy_end", busy, 1'b0);
    chk("t1_valid_end", m_valid, 1'b0);

    // Toggling backpressure.
    clear_obs(); preload(1, 16);
    for (int i = 0; i < 50; i++) step(1'b1, (i % 2) == 0, 1'b0, 0);
    check_seq("t2_order", 1, 16);
    chk("t2_beat_cnt", beat_cnt, 16'd32);

    // Single word.
    clear_obs(); preload(32'hA5, 1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 0);
    chk("t3_read_pulses", rd_pulses, 1);
    check_seq("t3_order", 32'hA5, 1);
    chk("t3_beat_cnt", beat_cnt, 16'd33);

    // Writer streaming one word per cycle.
    clear_obs();
    for (int i = 0; i < 160; i++) step(1'b1, 1'b1, 1'b1, i + 1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 0);
    check_seq("t4_order", 1, 160);
    begin
      int gaps = 0;
      for (int i = 1; i < pop_cyc.size(); i++)
        if (pop_cyc[i] != pop_cyc[i-1] + 1) gaps++;
      chk("t4_gaps", gaps, 0);
    end
    chk("t4_beat_cnt", beat_cnt, 16'd193);

    // enable drops after five reads, then resumes.
    clear_obs(); preload(1, 20);
    for (int i = 0; i < 12; i++) step(rd_pulses < 5, 1'b1, 1'b0, 0);
    chk("t5_stopped_valid", m_valid, 1'b0);
    chk("t5_stopped_le7", got.size() <= 7, 1'b1);
    chk("t5_stopped_reads", rd_pulses, 5);
    for (int i = 0; i < 25; i++) step(1'b1, 1'b1, 1'b0, 0);
    check_seq("t5_order", 1, 20);
    chk("t5_beat_cnt", beat_cnt, 16'd213);

    // Reset with the buffer full.
    clear_obs(); preload(1, 10);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 0);
    chk("t6_pre_valid", m_valid, 1'b1);
    chk("t6_pre_data", m_data, 32'd1);
    @(negedge clk);
    arstn = 1'b0;
    #1;
    chk("t6_rst_valid", m_valid, 1'b0);
    chk("t6_rst_beat_cnt", beat_cnt, 16'd0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_read", fifo_read, 1'b0);
    n_rd = 0; n_pop = 0; rd_last = 1'b0; exp_q.delete();
    @(posedge clk); @(posedge clk); #2;
    arstn = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 0);
    check_seq("t6_order", 3, 8);
    chk("t6_beat_cnt", beat_cnt, 16'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Read-side engine for the team's synchronous fifo. It drains the fifo through its read/empty/data_out port and presents the words on a valid/ready stream with full throughput (1 word/cycle). It absorbs the fifo's 1-cycle read latency with a 2-entry output buffer and never issues a read on an empty fifo. It sits between a fifo instance and any downstream stream consumer.

Parameters:
WIDTH, 32, data word width (must match the fifo WIDTH)
CNT_W, 16, width of the accepted-beat counter

Ports:
clk  in  1  system clock, rising edge
arstn  in  1  asynchronous active-low reset
enable  in  1  1 = allow new fifo reads; 0 = stop issuing reads (in-flight and buffered words still drain)
fifo_read  out  1  read strobe to fifo, combinational
fifo_data  in  WIDTH  fifo data_out, valid the cycle after a sampled read
fifo_empty  in  1  fifo empty flag, reflects occupancy after the last edge
m_data  out  WIDTH  stream data, registered
m_valid  out  1  stream valid, registered
m_ready  in  1  stream ready from consumer
beat_cnt  out  CNT_W  count of accepted beats (m_valid & m_ready), wraps modulo 2^CNT_W
busy  out  1  1 when rd_pend or any buffered word exists

Behaviour:
- Reset (arstn=0, async): buffer occupancy=0, rd_pend=0, m_valid=0, m_data=0, beat_cnt=0, busy=0. fifo_read is 0 while arstn=0. Words in flight or buffered are discarded. Release is synchronous to clk edge.
- Internal state: rd_pend (read issued at previous edge); 2-entry buffer (head/tail regs, occ 0..2); m_data/m_valid driven from head.
- pop = m_valid & m_ready.
- fifo_read = enable & !fifo_empty & (occ + rd_pend - pop < 2). Never asserted when fifo_empty=1.
- rd_pend <= fifo_read at each edge.
- When rd_pend=1, fifo_data is written at the edge into the tail slot. If pop occurs at the same edge, occ is unchanged and the order is preserved: head<=second entry or the incoming word.
- Latency: fifo non-empty with occ=0 in cycle 0 -> fifo_read=1 in cycle 0 -> rd_pend=1 in cycle 1 -> m_valid=1 in cycle 2.
- Throughput: with m_ready held at 1 and the fifo non-empty, fifo_read stays at 1 and m_valid stays at 1 every cycle. Steady state is occ=1, rd_pend=1.
- Backpressure: m_ready=0 -> m_valid and m_data hold stable until accepted (AXI-stream rule). Reads stop once occ+rd_pend reaches 2. No word is dropped or duplicated.
- The fifo empties during a burst -> the in-flight word is still captured. m_valid deasserts after the last buffered word is accepted.
- enable falls -> no read is issued that cycle. rd_pend and buffered words complete normally.
- beat_cnt increments on each pop and wraps from 2^CNT_W-1 to 0.
- busy = rd_pend | (occ != 0).
- Invariant: occ + rd_pend <= 2 at every edge. A violation is a bug. Add an immediate assertion for it.

Decomposition:
- fifo_pkg: shared WIDTH default and a stream beat struct typedef (data, valid) for use by the fifo, this reader and the benches.
- Sub-module stream_skid_buf: the 2-entry valid/ready buffer with push/pop/occ outputs. The top level holds only the read-issue logic, rd_pend and beat_cnt.

Test Plan:
- Preload the fifo with 1..16, m_ready=1, enable=1 -> fifo_read first at cycle 0, m_valid at cycle 2, m_data=1..16 on consecutive cycles, beat_cnt=16, then busy=0 and m_valid=0.
- Same preload with m_ready toggling 1,0,1,0 -> all 16 words delivered in order. m_data holds stable while m_ready=0. fifo_read is never 1 when occ+rd_pend=2.
- fifo with 1 word (0xA5) -> exactly one fifo_read pulse. Afterwards fifo_read=0 while fifo_empty=1. One beat of 0xA5 is delivered.
- Writer pushes i+1 each cycle for 160 cycles while m_ready=1 -> the output stream is 1..160 contiguous with no gap after the first valid.
- Drop enable mid-burst after 5 reads -> at most the in-flight/buffered words (at most 2 beyond the 5th accepted word) are delivered, then m_valid=0. enable=1 again -> the sequence resumes with the next value.
- Assert arstn=0 mid-burst with occ=2 -> m_valid=0, beat_cnt=0, busy=0 immediately (asynchronously). After release, reading restarts from the fifo's current head.
